// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues one instruction-memory
//   request at a time over a req/ack handshake and registers the returned word
//   and its PC into the IF/ID output register. A one-entry skid buffer catches
//   a response that lands while decode is stalled. Redirects flush everything;
//   a redirect that hits an outstanding request waits out (drains) that
//   request and throws its data away.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and address (stable until imem_ack)
//   imem_ack/imem_rdata response strobe and instruction word
//   redirect/redirect_pc taken branch: flush and refetch from redirect_pc
//   stall               decode cannot accept the output register this cycle
//   if_valid/if_instr/if_pc/if_op  IF/ID register (if_op = if_instr[31:21])
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [10:0]         if_op
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;  // skid occupied, no request issued
  localparam logic [1:0] DRAIN = 2'd3;  // waiting out a flushed request

  logic [1:0]          stateReg, stateNext;
  logic [PC_WIDTH-1:0] pcReg, pcNext;
  logic [PC_WIDTH-1:0] drainAddrReg, drainAddrNext;
  logic                ifValidReg, ifValidNext;
  logic [31:0]         ifInstrReg, ifInstrNext;
  logic [PC_WIDTH-1:0] ifPcReg, ifPcNext;
  logic [31:0]         skidInstrReg, skidInstrNext;
  logic [PC_WIDTH-1:0] skidPcReg, skidPcNext;
  logic                consume;

  // The skid is full exactly when the FSM is in FULL, so no separate flag.
  assign imem_req  = (stateReg == FETCH) || (stateReg == DRAIN);
  // While draining, the flushed address must stay on the bus until its ack.
  assign imem_addr = (stateReg == DRAIN) ? drainAddrReg : pcReg;
  assign consume   = ifValidReg && !stall;

  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    drainAddrNext = drainAddrReg;
    ifValidNext   = ifValidReg;
    ifInstrNext   = ifInstrReg;
    ifPcNext      = ifPcReg;
    skidInstrNext = skidInstrReg;
    skidPcNext    = skidPcReg;

    if (redirect) begin
      // Flush output and skid (skid empties by leaving FULL). An ack in this
      // same cycle closes the handshake, so only a still-open request drains.
      ifValidNext = 1'b0;
      pcNext      = redirect_pc;
      if (imem_req && !imem_ack) begin
        stateNext     = DRAIN;
        drainAddrNext = imem_addr;
      end else begin
        stateNext = FETCH;
      end
    end else begin
      case (stateReg)
        IDLE: stateNext = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pcNext = pcReg + PC_WIDTH'(4);
            if (!ifValidReg || consume) begin
              ifValidNext = 1'b1;
              ifInstrNext = imem_rdata;
              ifPcNext    = pcReg;
            end else begin
              skidInstrNext = imem_rdata;
              skidPcNext    = pcReg;
              stateNext     = FULL;
            end
          end else if (consume) begin
            ifValidNext = 1'b0;
          end
        end
        FULL: begin
          // Skid refills the output before any new request is made.
          if (consume) begin
            ifInstrNext = skidInstrReg;
            ifPcNext    = skidPcReg;
            stateNext   = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) stateNext = FETCH;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      pcReg        <= RESET_PC;
      drainAddrReg <= RESET_PC;
      ifValidReg   <= 1'b0;
      ifInstrReg   <= '0;
      ifPcReg      <= '0;
      skidInstrReg <= '0;
      skidPcReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      drainAddrReg <= drainAddrNext;
      ifValidReg   <= ifValidNext;
      ifInstrReg   <= ifInstrNext;
      ifPcReg      <= ifPcNext;
      skidInstrReg <= skidInstrNext;
      skidPcReg    <= skidPcNext;
    end
  end

  assign if_valid = ifValidReg;
  assign if_instr = ifInstrReg;
  assign if_pc    = ifPcReg;
  assign if_op    = ifInstrReg[31:21];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [10:0] if_op;

  int errors = 0;
  int checks = 0;
  int stepNo = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'h100)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_op(if_op)
  );

  // Memory model: acks once a request has been held for `latency` cycles
  // (latency 0 = same-cycle ack). Word contents derive from the address.
  logic [3:0] latency = 4'd0;
  logic [3:0] waitCnt = 4'd0;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return 32'hF8400000 + (lo - 32'h100);
  endfunction

  assign imem_ack   = imem_req && (waitCnt >= latency);
  assign imem_rdata = imem_ack ? memWord(imem_addr) : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) waitCnt <= 4'd0;
    else                                waitCnt <= waitCnt + 4'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h want %h", name, stepNo, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check state-driven outputs.
  task automatic step(input logic s, input logic r, input logic [63:0] rpc,
                      input logic [3:0] lat, input logic expReq, input logic chkA,
                      input logic [63:0] expAddr, input logic expValid,
                      input logic [63:0] expPc);
    logic [31:0] w;
    @(negedge clk);
    reset = 1'b0; stall = s; redirect = r; redirect_pc = rpc; latency = lat;
    #1;
    $display("step %0d stall=%0b redir=%0b req=%0b addr=%h valid=%0b pc=%h instr=%h",
             stepNo, s, r, imem_req, imem_addr, if_valid, if_pc, if_instr);
    chk("imem_req", {63'd0, imem_req}, {63'd0, expReq});
    if (chkA) chk("imem_addr", imem_addr, expAddr);
    chk("if_valid", {63'd0, if_valid}, {63'd0, expValid});
    if (expValid) begin
      w = memWord(expPc);
      chk("if_pc", if_pc, expPc);
      chk("if_instr", {32'd0, if_instr}, {32'd0, w});
      chk("if_op", {53'd0, if_op}, {53'd0, w[31:21]});
    end
    stepNo++;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    $display("reset check req=%0b addr=%h valid=%0b", imem_req, imem_addr, if_valid);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, 64'h100);
    chk("rst_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_instr", {32'd0, if_instr}, 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_op", {53'd0, if_op}, 64'd0);
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [63:0] rpc;
    logic        expReq;
    logic        chkA;
    logic [63:0] expAddr;
    logic        expValid;
    logic [63:0] expPc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Zero-wait memory: reset/IDLE, throughput, 3-cycle stall with skid,
    // then a redirect with no request outstanding.
    vecs[0]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h100, 1'b0, 64'h0};   // IDLE
    vecs[1]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h100, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h104, 1'b1, 64'h100}; // ack -> skid
    vecs[3]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b1, 64'h100}; // FULL
    vecs[4]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b1, 64'h100};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b1, 64'h100}; // skid moves
    vecs[6]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h108, 1'b1, 64'h104};
    vecs[7]  = '{1'b0, 1'b1, 64'h400, 1'b1, 1'b1, 64'h10C, 1'b1, 64'h108}; // redirect
    vecs[8]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h400, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h404, 1'b1, 64'h400};
    vecs[10] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h408, 1'b1, 64'h404};

    doReset(3);
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].s, vecs[i].r, vecs[i].rpc, 4'd0, vecs[i].expReq, vecs[i].chkA,
           vecs[i].expAddr, vecs[i].expValid, vecs[i].expPc);
      if (i == 2) chk("ldur_op", {53'd0, if_op}, {53'd0, 11'b11111000010});
    end

    // Slow memory, request to 0x40C left open, then reset abandons it.
    step(1'b0, 1'b0, 64'h0, 4'd3, 1'b1, 1'b1, 64'h40C, 1'b1, 64'h408);
    doReset(2);

    // Drain: 3-cycle memory, redirect to 0x200 one cycle into the 0x108 fetch.
    step(1'b0, 1'b1, 64'h108, 4'd3, 1'b0, 1'b1, 64'h100, 1'b0, 64'h0); // IDLE
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h108, 1'b0, 64'h0);
    step(1'b0, 1'b1, 64'h200, 4'd3, 1'b1, 1'b1, 64'h108, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h108, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h108, 1'b0, 64'h0); // drain ack
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0,   4'd3, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0); // ack 0x200

    // Simultaneous events under stall: redirect with skid full, then a
    // redirect coinciding with an ack while the output is held.
    step(1'b1, 1'b0, 64'h0,   4'd0, 1'b1, 1'b1, 64'h204, 1'b1, 64'h200); // skid <- 0x204
    step(1'b1, 1'b1, 64'h300, 4'd0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h200); // FULL + redirect
    step(1'b1, 1'b0, 64'h0,   4'd0, 1'b1, 1'b1, 64'h300, 1'b0, 64'h0);
    step(1'b1, 1'b1, 64'h500, 4'd0, 1'b1, 1'b1, 64'h304, 1'b1, 64'h300); // ack + redirect
    step(1'b0, 1'b0, 64'h0,   4'd0, 1'b1, 1'b1, 64'h500, 1'b0, 64'h0);

    // PC wrap.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd0, 1'b1, 1'b1, 64'h504, 1'b1, 64'h500);
    step(1'b0, 1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 64'h4, 1'b1, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the ARMv8 CPU. It holds the PC, issues one request at a time to instruction memory over a req/ack handshake, and registers the fetched word plus its PC into an IF/ID output register. The output register drives the opcode field `if_op` (instr[31:21]) straight into the control decoder. Branch redirects flush in-flight work, and a one-entry skid buffer absorbs responses that arrive while the decode side is stalled.

## Interface
- `PC_WIDTH`, 64: PC and address width.
- `RESET_PC`, 0: first fetch address after reset.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held with a stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  PC_WIDTH  fetch address.
- `imem_ack`  in  1  response valid; may assert in the same cycle as `imem_req` (zero wait) or any later cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `redirect`  in  1  taken branch or jump; flush and refetch.
- `redirect_pc`  in  PC_WIDTH  new PC, sampled when `redirect`=1.
- `stall`  in  1  downstream cannot accept this cycle.
- `if_valid`  out  1  output register holds a live instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  PC_WIDTH  address of `if_instr`.
- `if_op`  out  11  `if_instr[31:21]`, registered with `if_instr`.

## Operation
- **Consume:** the output is consumed when `if_valid && !stall`.
- **States:**
  - `IDLE`: only for the single cycle after reset; goes to `FETCH`.
  - `FETCH`: `imem_req=1`, `imem_addr=pc`.
  - `FULL`: skid full; no request issued.
  - `DRAIN`: a redirect arrived with a request outstanding. `imem_req` and the old `imem_addr` stay asserted until `imem_ack`, and that response is discarded.
- **Accepted ack in `FETCH`** (no redirect):
  - `pc <= pc + 4`, modulo 2^PC_WIDTH.
  - The word goes to the output register if that register is empty or consumed this cycle; otherwise it goes to the skid buffer and the state becomes `FULL`.
- **`FULL` → `FETCH`:** when the output is consumed. The skid contents move to the output register in that same cycle, and the skid empties.
- **Ordering:** the output register is refilled only in this order: skid first, then a new ack.
- **Redirect** (priority over everything except reset):
  - Output register and skid are cleared.
  - `pc <= redirect_pc`.
  - If `imem_req`=1 and `imem_ack`=0 this cycle, the next state is `DRAIN`; otherwise it is `FETCH`.
  - An ack coinciding with the redirect is discarded and needs no drain.
- **Redirect while in `DRAIN`:** updates `pc` again and stays in `DRAIN`.
- **`DRAIN` exit:** on ack, go to `FETCH` and issue `pc` the following cycle.
- **Reset mid-request:** any outstanding request is abandoned. The memory side must tolerate a dropped request.
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_op`=0, skid empty, `pc`=`RESET_PC`, state `IDLE`.

## Timing
- First `imem_req` is in the second cycle after `reset` deasserts (the `IDLE` cycle comes first).
- Ack in cycle N → `if_valid`/`if_instr` visible in cycle N+1.
- Throughput with zero-wait memory and no stall: one instruction per cycle, consecutive PCs +4.
- Redirect in cycle N:
  - `if_valid`=0 in N+1.
  - With no outstanding request, `imem_req` with `redirect_pc` in N+1.
  - With an outstanding request, the new request starts the cycle after the drain ack.
- `stall` never drops `imem_req` mid-handshake. It only blocks new requests through the `FULL` state.
- No instruction is lost or duplicated across `stall` and `redirect` combinations.

## Test plan
- **Reset:**
  - Stimulus: `RESET_PC`=0x100, zero-wait ack returning 0xF8400000 (LDUR opcode).
  - Required: after the `IDLE` cycle, `imem_addr`=0x100, then 0x104, 0x108.
  - Required: outputs are `if_pc`=0x100, `if_instr`=0xF8400000, `if_op`=11'b11111000010, one cycle after the ack.
- **Stall with skid:**
  - Stimulus: hold `stall`=1 for 3 cycles while acks arrive.
  - Required: output holds PC 0x100; skid takes 0x104; `imem_req` drops while `FULL`.
  - Required: after `stall` falls, 0x104 then 0x108 appear in order, with no gaps or repeats.
- **Redirect, no outstanding request:**
  - Stimulus: `redirect`=1, `redirect_pc`=0x400, zero-wait memory.
  - Required: `if_valid`=0 next cycle, `imem_addr`=0x400 next cycle, then 0x404.
- **Redirect mid-request (drain):**
  - Stimulus: memory with 3-cycle latency; redirect to 0x200 one cycle after the request to 0x108.
  - Required: `imem_addr` stays 0x108 until its ack; that data never appears on `if_*`.
  - Required: next request is 0x200.
- **Simultaneous events:**
  - Stimulus: redirect in the same cycle as an ack with `stall`=1 and the skid full.
  - Required: all buffered and acked data are discarded; next output is `if_pc`=`redirect_pc`.
- **PC wrap:**
  - Stimulus: redirect to 0xFFFF_FFFF_FFFF_FFFC.
  - Required: fetches 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
